sw_cfg_loader: RTL and testbench



---
 rtl/sw_cfg_loader.sv | 108 ++++++++++
 tb/tb_sw_cfg_loader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_cfg_loader.sv
// Serial capacitor-switch configuration loader: shifts a frame into a shadow register
// and applies it to sw on frame_tick. Optional even-parity check via SW_PARITY_CHK_EN.
module sw_cfg_loader #(
  parameter int CAP_NUM = 8,
  parameter int CNT_W   = $clog2(CAP_NUM + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  input  logic               cfg_bit,
  output logic               cfg_ready,
  input  logic               cfg_abort,
  input  logic               frame_tick,
  output logic [CAP_NUM-1:0] sw,
  output logic               sw_update,
  output logic               armed,
  output logic               cfg_err
);

`ifdef SW_PARITY_CHK_EN
  localparam int FRAME_LEN = CAP_NUM + 1;
`else
  localparam int FRAME_LEN = CAP_NUM;
`endif

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, ARMED} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [FRAME_LEN-1:0] shadow;
  logic                 accept;

  assign accept = cfg_valid && cfg_ready;

  // cfg_ready and armed are registered alongside the state so they never depend on cfg_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      shadow    <= '0;
      sw        <= '0;
      sw_update <= 1'b0;
      armed     <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      sw_update <= 1'b0;
      if (cfg_abort) begin
        state     <= IDLE;
        cnt       <= '0;
        shadow    <= '0;
        cfg_ready <= 1'b1;
        armed     <= 1'b0;
      end else begin
        case (state)
          IDLE, SHIFT: begin
            if (accept) begin
              for (int i = 0; i < FRAME_LEN; i++) begin
                if (cnt == CNT_W'(i)) shadow[i] <= cfg_bit;
              end
              if (state == IDLE) cfg_err <= 1'b0;
              if (cnt == CNT_W'(FRAME_LEN - 1)) begin
                state     <= CHECK;
                cnt       <= '0;
                cfg_ready <= 1'b0;
              end else begin
                state <= SHIFT;
                cnt   <= cnt + CNT_W'(1);
              end
            end
          end
          CHECK: begin
`ifdef SW_PARITY_CHK_EN
            if (^shadow) begin
              cfg_err   <= 1'b1;
              shadow    <= '0;
              state     <= IDLE;
              cfg_ready <= 1'b1;
            end else begin
              state <= ARMED;
              armed <= 1'b1;
            end
`else
            state <= ARMED;
            armed <= 1'b1;
`endif
          end
          ARMED: begin
            if (frame_tick) begin
              sw        <= shadow[CAP_NUM-1:0];
              sw_update <= 1'b1;
              shadow    <= '0;
              state     <= IDLE;
              cfg_ready <= 1'b1;
              armed     <= 1'b0;
            end
          end
          default: begin
            state     <= IDLE;
            cfg_ready <= 1'b1;
            armed     <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sw_cfg_loader.sv
// Self-checking bench for sw_cfg_loader: vector table, corner-case sequences and
// randomized frames against a frame-level model. Works with or without SW_PARITY_CHK_EN.
module tb_sw_cfg_loader;

`ifdef SW_PARITY_CHK_EN
  localparam bit PAR = 1'b1;
  localparam int L   = 9;
`else
  localparam bit PAR = 1'b0;
  localparam int L   = 8;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_valid, cfg_bit, cfg_abort, frame_tick;
  logic       cfg_ready, sw_update, armed, cfg_err;
  logic [7:0] sw;

  int checks = 0;
  int fails  = 0;

  logic [7:0] model_sw;
  bit         model_err;

  typedef struct {
    logic [7:0] data;
    bit         corrupt;
    int         gap;
    int         delay;
    logic [7:0] exp_sw;
    bit         exp_err;
  } vec_t;

  vec_t vecs[6];

  sw_cfg_loader #(.CAP_NUM(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cfg_valid  (cfg_valid),
    .cfg_bit    (cfg_bit),
    .cfg_ready  (cfg_ready),
    .cfg_abort  (cfg_abort),
    .frame_tick (frame_tick),
    .sw         (sw),
    .sw_update  (sw_update),
    .armed      (armed),
    .cfg_err    (cfg_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic sendBit(input logic b);
    checkOutput("ready_before_bit", cfg_ready, 1);
    cfg_valid = 1'b1;
    cfg_bit   = b;
    step();
    cfg_valid = 1'b0;
  endtask

  // Shift a whole frame; returns in the CHECK cycle
  task automatic sendFrame(input logic [7:0] data, input bit corrupt, input int gap);
    logic b;
    for (int k = 0; k < L; k++) begin
      b = (k < 8) ? data[k] : ((^data) ^ corrupt);
      sendBit(b);
      if (k == 0) checkOutput("err_clear_first_bit", cfg_err, 0);
      if (k < L - 1) begin
        for (int g = 0; g < gap; g++) begin
          step();
          checkOutput("ready_in_gap", cfg_ready, 1);
        end
      end
    end
    checkOutput("ready_in_check", cfg_ready, 0);
    checkOutput("armed_in_check", armed, 0);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input bit corrupt, input int gap, input int delay,
                               input logic [7:0] exp_sw, input bit exp_err);
    sendFrame(data, corrupt, gap);
    step();
    if (exp_err) begin
      checkOutput("parity_err_set", cfg_err, 1);
      checkOutput("armed_after_err", armed, 0);
      checkOutput("ready_after_err", cfg_ready, 1);
      checkOutput("sw_kept_on_err", sw, exp_sw);
    end else begin
      checkOutput("armed_rise", armed, 1);
      checkOutput("ready_in_armed", cfg_ready, 0);
      for (int d = 0; d < delay; d++) begin
        step();
        checkOutput("armed_wait", armed, 1);
        checkOutput("sw_before_tick", sw, model_sw);
      end
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
      checkOutput("sw_applied", sw, exp_sw);
      checkOutput("sw_update_pulse", sw_update, 1);
      checkOutput("armed_cleared", armed, 0);
      checkOutput("ready_after_tick", cfg_ready, 1);
      step();
      checkOutput("sw_update_one_cycle", sw_update, 0);
      checkOutput("err_after_load", cfg_err, exp_err);
    end
    model_sw  = exp_sw;
    model_err = exp_err;
  endtask

  initial begin
    logic [7:0] data;
    bit         corrupt;
    int         k;

    cfg_valid  = 1'b0;
    cfg_bit    = 1'b0;
    cfg_abort  = 1'b0;
    frame_tick = 1'b0;
    rst_n      = 1'b1;
    #2 rst_n   = 1'b0;
    #2;
    checkOutput("reset_sw", sw, 0);
    checkOutput("reset_sw_update", sw_update, 0);
    checkOutput("reset_armed", armed, 0);
    checkOutput("reset_err", cfg_err, 0);
    checkOutput("reset_ready", cfg_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n  = 1'b1;
    model_sw  = 8'h00;
    model_err = 1'b0;

    vecs[0] = '{8'hA5, 1'b0, 0, 3, 8'hA5, 1'b0};
    if (PAR) vecs[1] = '{8'h3C, 1'b1, 0, 0, 8'hA5, 1'b1};
    else     vecs[1] = '{8'h3C, 1'b0, 0, 0, 8'h3C, 1'b0};
    vecs[2] = '{8'h0F, 1'b0, 1, 1, 8'h0F, 1'b0};
    vecs[3] = '{8'h81, 1'b0, 0, 0, 8'h81, 1'b0};
    vecs[4] = '{8'h81, 1'b0, 2, 0, 8'h81, 1'b0};
    vecs[5] = '{8'hC3, 1'b0, 0, 2, 8'hC3, 1'b0};

    for (int i = 0; i < 6; i++)
      applyStimulus(vecs[i].data, vecs[i].corrupt, vecs[i].gap, vecs[i].delay, vecs[i].exp_sw, vecs[i].exp_err);

    // Abort and frame_tick together while armed: abort wins
    sendFrame(8'h33, 1'b0, 0);
    step();
    checkOutput("armed_before_abort", armed, 1);
    cfg_abort  = 1'b1;
    frame_tick = 1'b1;
    step();
    cfg_abort  = 1'b0;
    checkOutput("abort_sw_kept", sw, model_sw);
    checkOutput("abort_no_update", sw_update, 0);
    checkOutput("abort_armed_low", armed, 0);
    checkOutput("abort_ready_high", cfg_ready, 1);
    step();
    frame_tick = 1'b0;
    checkOutput("tick_idle_ignored", sw_update, 0);
    checkOutput("tick_idle_sw", sw, model_sw);

    // frame_tick during CHECK is missed
    sendFrame(8'h6C, 1'b0, 0);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    checkOutput("check_tick_armed", armed, 1);
    checkOutput("check_tick_no_update", sw_update, 0);
    checkOutput("check_tick_sw", sw, model_sw);
    step();
    checkOutput("still_armed", armed, 1);
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    checkOutput("late_tick_sw", sw, 8'h6C);
    checkOutput("late_tick_update", sw_update, 1);
    model_sw = 8'h6C;

    // Abort after four bits, then a clean 0xFF frame
    sendBit(1'b0);
    sendBit(1'b1);
    sendBit(1'b0);
    sendBit(1'b0);
    cfg_abort = 1'b1;
    step();
    cfg_abort = 1'b0;
    checkOutput("abort_shift_ready", cfg_ready, 1);
    checkOutput("abort_shift_sw", sw, model_sw);
    applyStimulus(8'hFF, 1'b0, 0, 0, 8'hFF, 1'b0);

    // Async reset while armed clears everything immediately
    applyStimulus(8'h5A, 1'b0, 0, 0, 8'h5A, 1'b0);
    sendFrame(8'h12, 1'b0, 0);
    step();
    checkOutput("armed_before_reset", armed, 1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_sw", sw, 0);
    checkOutput("midreset_armed", armed, 0);
    checkOutput("midreset_ready", cfg_ready, 1);
    checkOutput("midreset_err", cfg_err, 0);
    rst_n     = 1'b1;
    model_sw  = 8'h00;
    model_err = 1'b0;
    step();

    // Randomized frames against the frame-level model
    for (int n = 0; n < 40; n++) begin
      data = 8'($urandom);
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, L - 1);
        for (int i = 0; i < k; i++) sendBit(1'($urandom));
        cfg_valid = 1'b1;
        cfg_bit   = 1'b1;
        cfg_abort = 1'b1;
        step();
        cfg_valid = 1'b0;
        cfg_abort = 1'b0;
        if (k > 0) model_err = 1'b0;
        checkOutput("rand_abort_ready", cfg_ready, 1);
        checkOutput("rand_abort_armed", armed, 0);
        checkOutput("rand_abort_sw", sw, model_sw);
        checkOutput("rand_abort_err", cfg_err, model_err);
      end else begin
        corrupt = PAR ? ($urandom_range(0, 3) == 0) : 1'b0;
        applyStimulus(data, corrupt, $urandom_range(0, 2), $urandom_range(0, 3),
                      corrupt ? model_sw : data, corrupt);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
